// File: rtl/uart_target_rx_if.sv
// rtl/uart_target_rx_if.sv - serial input and decoded command outputs of the UART target receiver
interface uart_target_rx_if;
    logic       rx;
    logic [3:0] target;
    logic       load;
    logic       clr_req;
    logic       frame_err;
    logic       busy;
    logic [7:0] rx_byte;

    // Receiver side: consumes the serial line, drives the decoded results
    modport master (
        input  rx,
        output target,
        output load,
        output clr_req,
        output frame_err,
        output busy,
        output rx_byte
    );

    // Line/consumer side: drives the serial line, observes the decoded results
    modport slave (
        output rx,
        input  target,
        input  load,
        input  clr_req,
        input  frame_err,
        input  busy,
        input  rx_byte
    );
endinterface

// File: rtl/uart_target_rx.sv
// rtl/uart_target_rx.sv - UART 8N1 receiver decoding load-target and clear-counter command bytes
module uart_target_rx #(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [3:0] CMD_LOAD     = 4'hA,
    parameter logic [3:0] CMD_CLR      = 4'hF
) (
    input logic              clk,
    input logic              rst,
    uart_target_rx_if.master bus
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic              r_sync1;
    logic              r_sync2;
    logic [2:0]        r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic [3:0]        r_target;
    logic [7:0]        r_rx_byte;
    logic              r_load;
    logic              r_clr_req;
    logic              r_frame_err;

    logic w_rxs;
    logic w_full_bit;
    logic w_half_bit;

    assign w_rxs      = r_sync2;
    assign w_full_bit = (r_baud == BAUD_LAST);
    assign w_half_bit = (r_baud == HALF_LAST);

    // Two-flop synchronizer for the asynchronous serial line; resets to idle-high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;
        end
    end

    // Frame FSM: start detection, mid-bit sampling, stop check and command decode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_baud      <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_target    <= 4'h0;
            r_rx_byte   <= 8'h00;
            r_load      <= 1'b0;
            r_clr_req   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            r_load      <= 1'b0;
            r_clr_req   <= 1'b0;
            r_frame_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (!w_rxs) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    // Mid-start check rejects glitches shorter than half a bit
                    if (w_half_bit) begin
                        r_baud    <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= w_rxs ? S_IDLE : S_DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end

                S_DATA: begin
                    if (w_full_bit) begin
                        r_baud    <= '0;
                        r_shift   <= {w_rxs, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end

                S_STOP: begin
                    if (w_full_bit) begin
                        r_baud <= '0;
                        if (w_rxs) begin
                            // Good frame: publish byte and decode the command nibble
                            r_rx_byte <= r_shift;
                            if (r_shift[7:4] == CMD_LOAD) begin
                                r_target <= r_shift[3:0];
                                r_load   <= 1'b1;
                            end else if (r_shift[7:4] == CMD_CLR) begin
                                r_clr_req <= 1'b1;
                            end
                            r_state <= S_IDLE;
                        end else begin
                            // Bad stop bit: drop the byte and wait out any break
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end

                S_WAIT_IDLE: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.target    = r_target;
    assign bus.rx_byte   = r_rx_byte;
    assign bus.load      = r_load;
    assign bus.clr_req   = r_clr_req;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_target_rx.sv
// tb/tb_uart_target_rx.sv - directed bench for uart_target_rx with a frame-level expectation model
module tb_uart_target_rx;

    localparam int CPB     = 16;
    localparam int LATENCY = 2 + CPB / 2 + 9 * CPB + 1;

    localparam int K_NONE = 0;
    localparam int K_LOAD = 1;
    localparam int K_CLR  = 2;
    localparam int K_FE   = 3;

    typedef struct {
        int         kind;
        int         due;
        logic [3:0] tgt;
        logic [7:0] rb;
    } ev_t;

    logic clk;
    logic rst;
    int   cyc;
    int   vectors;
    int   miscompares;

    ev_t        q[$];
    int         load_cycs[$];
    logic [3:0] pm_target;
    logic [7:0] pm_rb;
    logic [3:0] exp_t;
    logic [7:0] exp_rb;

    uart_target_rx_if u_if ();

    uart_target_rx #(
        .CLKS_PER_BIT(CPB),
        .CMD_LOAD    (4'hA),
        .CMD_CLR     (4'hF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        vectors++;
        if (got < lo || got > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] kind_mask(input int k);
        case (k)
            K_LOAD:  return 3'b001;
            K_CLR:   return 3'b010;
            K_FE:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Frame-level model: what one transmitted byte must do to the outputs
    task automatic expect_frame(input logic [7:0] b, input bit stop_ok, input int start);
        ev_t e;
        e.due = start + LATENCY;
        if (!stop_ok) begin
            e.kind = K_FE;
        end else begin
            pm_rb = b;
            if (b[7:4] == 4'hA) begin
                e.kind    = K_LOAD;
                pm_target = b[3:0];
            end else if (b[7:4] == 4'hF) begin
                e.kind = K_CLR;
            end else begin
                e.kind = K_NONE;
            end
        end
        e.tgt = pm_target;
        e.rb  = pm_rb;
        q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low,
                              output int start);
        start = cyc;
        expect_frame(b, stop_ok, start);
        u_if.rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            u_if.rx = b[i];
            tick(CPB);
        end
        u_if.rx = stop_ok;
        tick(CPB);
        if (!stop_ok) begin
            tick(extra_low);
            check("busy_during_break", u_if.busy, 1);
            u_if.rx = 1'b1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        #1;
        check("events_pending", q.size(), 0);
    endtask

    // Per-cycle compare of the DUT against the frame-level model
    always @(negedge clk) begin
        logic [2:0] obs;
        ev_t        e;
        if (rst) begin
            exp_t  = 4'h0;
            exp_rb = 8'h00;
        end else begin
            obs = {u_if.frame_err, u_if.clr_req, u_if.load};
            check("load_clr_exclusive", {31'd0, u_if.load & u_if.clr_req}, 0);
            if (obs != 3'b000) begin
                if (q.size() == 0 || q[0].kind == K_NONE) begin
                    check("unexpected_strobe", {29'd0, obs}, 0);
                end else begin
                    e = q.pop_front();
                    check("strobe_kind", {29'd0, obs}, {29'd0, kind_mask(e.kind)});
                    check_range("strobe_latency", cyc, e.due - 1, e.due + 1);
                    exp_t  = e.tgt;
                    exp_rb = e.rb;
                    if (u_if.load) load_cycs.push_back(cyc);
                end
            end else if (q.size() > 0 && cyc >= q[0].due + 1) begin
                if (q[0].kind == K_NONE) begin
                    e      = q.pop_front();
                    exp_t  = e.tgt;
                    exp_rb = e.rb;
                end else if (cyc > q[0].due + 1) begin
                    e = q.pop_front();
                    check("missing_strobe", 0, {29'd0, kind_mask(e.kind)});
                    exp_t  = e.tgt;
                    exp_rb = e.rb;
                end
            end
            if (!(q.size() > 0 && cyc >= q[0].due - 1)) begin
                check("target", {28'd0, u_if.target}, {28'd0, exp_t});
                check("rx_byte", {24'd0, u_if.rx_byte}, {24'd0, exp_rb});
            end
        end
    end

    initial begin
        int  s0;
        int  s1;
        int  g;
        bit  seen_busy;
        logic [7:0] ab;

        vectors     = 0;
        miscompares = 0;
        pm_target   = 4'h0;
        pm_rb       = 8'h00;
        rst         = 1'b1;
        u_if.rx     = 1'b1;

        tick(4);
        check("rst_target", {28'd0, u_if.target}, 0);
        check("rst_rx_byte", {24'd0, u_if.rx_byte}, 0);
        check("rst_load", {31'd0, u_if.load}, 0);
        check("rst_clr_req", {31'd0, u_if.clr_req}, 0);
        check("rst_frame_err", {31'd0, u_if.frame_err}, 0);
        check("rst_busy", {31'd0, u_if.busy}, 0);
        rst = 1'b0;
        tick(4);

        // Load command 0xA7
        send_frame(8'hA7, 1'b1, 0, s0);
        drain();
        check("a7_target", {28'd0, u_if.target}, 32'h7);
        check("a7_rx_byte", {24'd0, u_if.rx_byte}, 32'hA7);
        check("a7_load_count", load_cycs.size(), 1);
        if (load_cycs.size() >= 1) check_range("a7_latency", load_cycs[0] - s0, 154, 156);
        tick(10);

        // Back-to-back loads 0xA3 then 0xAC
        send_frame(8'hA3, 1'b1, 0, s0);
        send_frame(8'hAC, 1'b1, 0, s1);
        drain();
        check("b2b_load_count", load_cycs.size(), 3);
        if (load_cycs.size() >= 3) check("b2b_spacing", load_cycs[2] - load_cycs[1], 160);
        check("b2b_target", {28'd0, u_if.target}, 32'hC);
        tick(10);

        // Clear command, then a byte with no command tag
        send_frame(8'hF0, 1'b1, 0, s0);
        drain();
        check("clr_target_held", {28'd0, u_if.target}, 32'hC);
        check("clr_rx_byte", {24'd0, u_if.rx_byte}, 32'hF0);
        send_frame(8'h55, 1'b1, 0, s0);
        drain();
        check("plain_rx_byte", {24'd0, u_if.rx_byte}, 32'h55);
        check("plain_target", {28'd0, u_if.target}, 32'hC);
        tick(10);

        // Framing error with a held break, then recovery
        send_frame(8'hA9, 1'b0, 40, s0);
        tick(4);
        check("break_busy_released", {31'd0, u_if.busy}, 0);
        drain();
        check("fe_target_held", {28'd0, u_if.target}, 32'hC);
        check("fe_rx_byte_held", {24'd0, u_if.rx_byte}, 32'h55);
        send_frame(8'hA1, 1'b1, 0, s0);
        drain();
        check("recover_target", {28'd0, u_if.target}, 32'h1);
        tick(10);

        // Short low glitch must be rejected
        g         = cyc;
        seen_busy = 1'b0;
        u_if.rx   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            seen_busy |= u_if.busy;
        end
        u_if.rx = 1'b1;
        while (u_if.busy && (cyc - g) < 12) begin
            tick(1);
        end
        check("glitch_busy_seen", {31'd0, seen_busy}, 1);
        check("glitch_busy_cleared", {31'd0, u_if.busy}, 0);
        tick(200);
        check("glitch_target", {28'd0, u_if.target}, 32'h1);

        // Reset in the middle of bit 4 of 0xAB, held to the end of that frame
        ab      = 8'hAB;
        u_if.rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            u_if.rx = ab[i];
            tick(CPB);
        end
        u_if.rx = ab[4];
        tick(CPB / 2);
        rst = 1'b1;
        q.delete();
        pm_target = 4'h0;
        pm_rb     = 8'h00;
        tick(2);
        check("midrst_target", {28'd0, u_if.target}, 0);
        check("midrst_rx_byte", {24'd0, u_if.rx_byte}, 0);
        check("midrst_busy", {31'd0, u_if.busy}, 0);
        check("midrst_strobes", {29'd0, u_if.frame_err, u_if.clr_req, u_if.load}, 0);
        tick(CPB / 2 - 2);
        for (int i = 5; i < 8; i++) begin
            u_if.rx = ab[i];
            tick(CPB);
        end
        u_if.rx = 1'b1;
        tick(2 * CPB);
        rst = 1'b0;
        tick(4);
        send_frame(8'hA2, 1'b1, 0, s0);
        drain();
        check("post_rst_target", {28'd0, u_if.target}, 32'h2);
        check("post_rst_rx_byte", {24'd0, u_if.rx_byte}, 32'hA2);
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_target_rx.md
Name: uart_target_rx

Overview:
- UART 8N1 receiver and command decoder. Sits directly upstream of the target counter stage.
- Converts serial bytes into the 4-bit target value and a one-cycle load strobe that the counter latches.
- Also decodes a counter-clear command and flags framing errors.
- Replaces the manual switch inputs for the target value and the load line.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per UART bit. Must be ≥4 and even.
- CMD_LOAD, 4'hA: upper-nibble tag for a "load target" byte.
- CMD_CLR, 4'hF: upper-nibble tag for a "clear counter" byte.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- rx  in  1  asynchronous serial input; idle high.
- target  out  4  last loaded target value; held between loads.
- load  out  1  one-cycle strobe; target is valid in the same cycle.
- clr_req  out  1  one-cycle strobe requesting a counter reset.
- frame_err  out  1  one-cycle strobe on bad stop bit.
- busy  out  1  high while a frame is being received (any state other than IDLE).
- rx_byte  out  8  last correctly framed byte, for debug; held.

Behaviour:
- Reset values:
  - target = 0, rx_byte = 0.
  - load = clr_req = frame_err = busy = 0.
  - Synchronizer flops = 1. FSM = IDLE. Bit counter and baud counter = 0.
  - Reset mid-frame aborts the frame. No strobe is emitted.
- rx passes through a 2-flop synchronizer. All FSM decisions use the synchronized value rxs.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: rxs == 0 → START, baud counter cleared.
  - START: after CLKS_PER_BIT/2 cycles, sample rxs.
    - rxs == 1 → false start, back to IDLE.
    - rxs == 0 → DATA, baud counter cleared, bit index 0.
  - DATA: every CLKS_PER_BIT cycles, sample rxs into the shift register, LSB first.
    - After bit index 7 is sampled → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxs.
    - rxs == 1 → decode the byte, go to IDLE.
    - rxs == 0 → frame_err pulse, byte discarded (rx_byte unchanged), go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs == 1, then go to IDLE. This prevents a break condition from retriggering a frame.
- Decode happens in the cycle after the valid stop sample. Strobes are high exactly one clk cycle.
  - Upper nibble == CMD_LOAD: target ← byte[3:0], load = 1.
  - Upper nibble == CMD_CLR: clr_req = 1; target unchanged.
  - Any other upper nibble: no strobe. rx_byte is still updated.
- rx_byte is updated on every correctly framed byte.
- Latency from the falling start edge at the rx pin to the strobe is 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles, ±1. This is 155 cycles ±1 at the default.
- Back-to-back frames: a new start bit is accepted in the first IDLE cycle after STOP, so there is no inter-frame gap requirement.
- load and clr_req are never high in the same cycle.
- Counters:
  - Baud counter width is clog2(CLKS_PER_BIT). It wraps to 0 at each sample point.
  - Bit index is 3 bits.
- Glitch rejection: a start pulse low for fewer than CLKS_PER_BIT/2 cycles is rejected at the mid-start check.

Test Plan:
- Reset, then send 0xA7 at 16 clk/bit → load high one cycle, target = 4'h7, rx_byte = 8'hA7, clr_req = 0, frame_err = 0. Strobe 155 ±1 cycles after the start edge.
- Send 0xA3 then immediately 0xAC, back to back → two load pulses; target = 3, then 12. The second pulse comes 160 cycles after the first.
- Send 0xF0 → clr_req one-cycle pulse, load = 0, target unchanged from its previous value. Send 0x55 → no strobe, rx_byte = 8'h55.
- Send 0xA9 with the stop bit forced to 0, holding rx low 40 more cycles → frame_err one pulse, no load, target and rx_byte unchanged, busy high until rx returns high, then 0xA1 is received normally with target = 1.
- Drive a 5-cycle low glitch on rx → no strobe, busy returns to 0 within 12 cycles.
- Assert rst during bit 4 of 0xAB → all outputs return to reset values. The remaining bits of that frame produce no strobe; the next frame 0xA2 gives target = 2.
